// File: rtl/vpu_disp_pkg.sv
// ============================================================================
//  Module      : vpu_disp_pkg
//  Description : Shared types for the matrix unit command dispatcher:
//                geometry opcodes, the packed command record and the
//                dispatcher FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vpu_disp_pkg;

  // Geometry opcodes understood by the matrix unit
  localparam logic [3:0] OP_CRT   = 4'h0;  // create object
  localparam logic [3:0] OP_TRANS = 4'h4;  // translate object
  localparam logic [3:0] OP_ROTL  = 4'h6;  // rotate object

  // One queued command; v[0] occupies the least significant 16 bits (151 bits total)
  typedef struct packed {
    logic [3:0]       op;
    logic [3:0]       code;
    logic [1:0]       obj_type;
    logic [7:0]       color;
    logic [4:0]       obj_num;
    logic [7:0][15:0] v;
  } gmt_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_ARM   = 3'd3,
    ST_WAIT  = 3'd4
  } disp_state_t;

  // Create commands are the only ones that consume object memory
  function automatic logic is_create(gmt_cmd_t c);
    return (c.op == OP_CRT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_cmd_fifo.sv
// ============================================================================
//  Module      : disp_cmd_fifo
//  Description : DEPTH-entry synchronous FIFO of gmt_cmd_t records.
//                Simultaneous push and pop allowed; push ignored when full,
//                pop ignored when empty. Head is read combinationally.
//  Ports       : clk, rst_n (sync, active low)
//                i_push / i_push_data  - write request and record
//                i_pop                 - consume head
//                o_head                - current head record
//                o_level / o_full / o_empty - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_cmd_fifo
  import vpu_disp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  gmt_cmd_t               i_push_data,
  input  logic                   i_pop,
  output gmt_cmd_t               o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int            AW           = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL_LEVEL = (AW + 1)'(DEPTH);

  gmt_cmd_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == C_FULL_LEVEL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage needs no reset; validity is tracked by the level counter
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers are exactly AW bits wide so DEPTH (power of 2) wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + (AW + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - (AW + 1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gmt_cmd_dispatcher.sv
// ============================================================================
//  Module      : gmt_cmd_dispatcher
//  Description : Initiator side of the matrix unit go/busy command interface.
//                Queues CPU geometry commands and issues them one at a time:
//                pop -> CHECK -> go pulse -> wait for busy to rise and fall.
//                Create commands are dropped while object memory is full.
//  Options     : DISP_STATS_EN - adds saturating 16-bit counters for issued,
//                dropped and arm-timeout commands (stat_* outputs).
//  Ports       : clk, rst_n (sync, active low)
//                cmd_valid/cmd_ready + cmd_* fields - CPU command input
//                busy, obj_mem_full                 - matrix unit status
//                go + gmt_op/gmt_code/obj_type/obj_color/obj_num_in/v0..v7
//                                                   - held command to matrix unit
//                idle, drop_full, arm_timeout, fifo_level - status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gmt_cmd_dispatcher
  import vpu_disp_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ARM_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [3:0]             cmd_code,
  input  logic [1:0]             cmd_obj_type,
  input  logic [7:0]             cmd_color,
  input  logic [4:0]             cmd_obj_num,
  input  logic [127:0]           cmd_v,
  input  logic                   busy,
  input  logic                   obj_mem_full,
  output logic                   go,
  output logic [3:0]             gmt_op,
  output logic [3:0]             gmt_code,
  output logic [1:0]             obj_type,
  output logic [7:0]             obj_color,
  output logic [4:0]             obj_num_in,
  output logic [15:0]            v0,
  output logic [15:0]            v1,
  output logic [15:0]            v2,
  output logic [15:0]            v3,
  output logic [15:0]            v4,
  output logic [15:0]            v5,
  output logic [15:0]            v6,
  output logic [15:0]            v7,
  output logic                   idle,
  output logic                   drop_full,
  output logic                   arm_timeout,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef DISP_STATS_EN
  ,
  output logic [15:0]            stat_issued,
  output logic [15:0]            stat_dropped,
  output logic [15:0]            stat_timeouts
`endif
);

  localparam int            CW         = $clog2(ARM_TIMEOUT) + 1;
  localparam logic [CW-1:0] C_ARM_LAST = CW'(ARM_TIMEOUT - 1);

  disp_state_t r_state;
  disp_state_t w_state_nxt;
  gmt_cmd_t    r_cmd;
  gmt_cmd_t    w_in_cmd;
  gmt_cmd_t    w_head;
  logic [CW-1:0] r_arm_cnt;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_go;
  logic        w_drop;
  logic        w_arm_to;
  logic        w_cnt_clr;
  logic        w_cnt_inc;

  assign w_in_cmd  = {cmd_op, cmd_code, cmd_obj_type, cmd_color, cmd_obj_num, cmd_v};
  assign cmd_ready = rst_n && !w_full;
  assign w_push    = cmd_valid && cmd_ready;

  disp_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_in_cmd),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (fifo_level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Next-state and pulse outputs; everything is forced low while in reset
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_go        = 1'b0;
    w_drop      = 1'b0;
    w_arm_to    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Foreign activity on the matrix unit: hold here until it is free
          if (!busy) begin
            if (is_create(r_cmd) && obj_mem_full) begin
              w_drop      = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          w_go        = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_ARM;
        end
        ST_ARM: begin
          if (busy) begin
            w_state_nxt = ST_WAIT;
          end else if (r_arm_cnt == C_ARM_LAST) begin
            w_arm_to    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_WAIT: begin
          if (!busy) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Field registers load only on pop, so they stay stable from CHECK until
  // the next command is taken out of the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_arm_cnt <= '0;
      r_cmd     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr) begin
        r_arm_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_arm_cnt <= r_arm_cnt + CW'(1);
      end
      if (w_pop) r_cmd <= w_head;
    end
  end

  assign go          = w_go;
  assign drop_full   = w_drop;
  assign arm_timeout = w_arm_to;
  assign idle        = rst_n && w_empty && (r_state == ST_IDLE);
  assign gmt_op      = r_cmd.op;
  assign gmt_code    = r_cmd.code;
  assign obj_type    = r_cmd.obj_type;
  assign obj_color   = r_cmd.color;
  assign obj_num_in  = r_cmd.obj_num;
  assign v0          = r_cmd.v[0];
  assign v1          = r_cmd.v[1];
  assign v2          = r_cmd.v[2];
  assign v3          = r_cmd.v[3];
  assign v4          = r_cmd.v[4];
  assign v5          = r_cmd.v[5];
  assign v6          = r_cmd.v[6];
  assign v7          = r_cmd.v[7];

`ifdef DISP_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_dropped;
  logic [15:0] r_stat_timeouts;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_issued   <= '0;
      r_stat_dropped  <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (w_go && (r_stat_issued != 16'hFFFF))      r_stat_issued   <= r_stat_issued + 16'd1;
      if (w_drop && (r_stat_dropped != 16'hFFFF))   r_stat_dropped  <= r_stat_dropped + 16'd1;
      if (w_arm_to && (r_stat_timeouts != 16'hFFFF)) r_stat_timeouts <= r_stat_timeouts + 16'd1;
    end
  end

  assign stat_issued   = r_stat_issued;
  assign stat_dropped  = r_stat_dropped;
  assign stat_timeouts = r_stat_timeouts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gmt_cmd_dispatcher.sv
// ============================================================================
//  Module      : tb_gmt_cmd_dispatcher
//  Description : Self-checking bench for gmt_cmd_dispatcher. A behavioural
//                matrix-unit responder drives busy; a monitor logs go / drop /
//                timeout events which each scenario task compares against an
//                expected event list built from the command stream.
//  Options     : DISP_STATS_EN - also checks the statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gmt_cmd_dispatcher;

  localparam int DEPTH  = 4;
  localparam int ARM_TO = 8;

  typedef struct packed {
    logic [3:0]   op;
    logic [3:0]   code;
    logic [1:0]   typ;
    logic [7:0]   color;
    logic [4:0]   num;
    logic [127:0] v;
  } cmd_t;

  // kind: 1 = go issued, 2 = dropped (memory full), 3 = arm timeout
  typedef struct {
    int   kind;
    cmd_t c;
    int   cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_op = '0, cmd_code = '0;
  logic [1:0] cmd_obj_type = '0;
  logic [7:0] cmd_color = '0;
  logic [4:0] cmd_obj_num = '0;
  logic [127:0] cmd_v = '0;
  logic busy = 1'b0;
  logic obj_mem_full = 1'b0;
  logic go, idle, drop_full, arm_timeout;
  logic [3:0] gmt_op, gmt_code;
  logic [1:0] obj_type;
  logic [7:0] obj_color;
  logic [4:0] obj_num_in;
  logic [15:0] v0, v1, v2, v3, v4, v5, v6, v7;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef DISP_STATS_EN
  logic [15:0] stat_issued, stat_dropped, stat_timeouts;
`endif

  always #5 clk = ~clk;

  gmt_cmd_dispatcher #(.DEPTH(DEPTH), .ARM_TIMEOUT(ARM_TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_code(cmd_code), .cmd_obj_type(cmd_obj_type),
    .cmd_color(cmd_color), .cmd_obj_num(cmd_obj_num), .cmd_v(cmd_v),
    .busy(busy), .obj_mem_full(obj_mem_full), .go(go),
    .gmt_op(gmt_op), .gmt_code(gmt_code), .obj_type(obj_type),
    .obj_color(obj_color), .obj_num_in(obj_num_in),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7),
    .idle(idle), .drop_full(drop_full), .arm_timeout(arm_timeout),
    .fifo_level(fifo_level)
`ifdef DISP_STATS_EN
    , .stat_issued(stat_issued), .stat_dropped(stat_dropped), .stat_timeouts(stat_timeouts)
`endif
  );

  cmd_t w_out;
  assign w_out = {gmt_op, gmt_code, obj_type, obj_color, obj_num_in, v7, v6, v5, v4, v3, v2, v1, v0};

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   resp_mode = 0;      // 0 responds to go, 1 never responds, 2 busy driven by task
  int   busy_len = 5;
  int   busy_cnt = 0;
  int   hold_viol = 0, go_busy_viol = 0, go_double = 0;
  bit   tracking = 0, seen_busy = 0, prev_go = 0;
  cmd_t track_snap;
  bit   model_full = 0;
  int   m_issued = 0, m_dropped = 0, m_timeouts = 0;
  ev_t  ev_q[$];
  ev_t  exp_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor + matrix-unit responder (sample first, then drive busy)
  initial forever begin
    @(negedge clk);
    if (!rst_n) tracking = 0;
    if (go) begin
      ev_q.push_back('{1, w_out, cyc});
      if (busy) go_busy_viol++;
      if (prev_go) go_double++;
      tracking = 1; seen_busy = 0; track_snap = w_out;
    end else if (tracking) begin
      if (w_out !== track_snap) hold_viol++;
      if (busy) seen_busy = 1;
      else if (seen_busy) tracking = 0;
    end
    if (arm_timeout) begin
      ev_q.push_back('{3, w_out, cyc});
      tracking = 0;
    end
    if (drop_full) ev_q.push_back('{2, w_out, cyc});
    prev_go = go;
    if (resp_mode == 0) begin
      if (busy_cnt > 0) begin busy = 1; busy_cnt--; end
      else busy = 0;
      if (go) busy_cnt = busy_len;
    end else if (resp_mode == 1) begin
      busy = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int s = $urandom_range(0, 3);
    c.op    = (s == 0) ? 4'h0 : (s == 1) ? 4'h4 : (s == 2) ? 4'h6 : 4'($urandom_range(1, 15));
    c.code  = 4'($urandom);
    c.typ   = 2'($urandom_range(1, 3));
    c.color = 8'($urandom);
    c.num   = 5'($urandom);
    c.v     = {$urandom, $urandom, $urandom, $urandom};
    return c;
  endfunction

  // Reference: creates are dropped while memory is full, others issue once;
  // an unanswered go ends in one timeout for that same command.
  function automatic void model_expect(cmd_t c, bit responds);
    if (c.op == 4'h0 && model_full) begin
      exp_q.push_back('{2, c, 0}); m_dropped++;
    end else begin
      exp_q.push_back('{1, c, 0}); m_issued++;
      if (!responds) begin exp_q.push_back('{3, c, 0}); m_timeouts++; end
    end
  endfunction

  // Called at a negedge; returns the cycle in which the transfer happened
  task automatic push(input cmd_t c, output int acc_cyc);
    int k = 0;
    cmd_valid = 1; cmd_op = c.op; cmd_code = c.code; cmd_obj_type = c.typ;
    cmd_color = c.color; cmd_obj_num = c.num; cmd_v = c.v;
    while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, k);
    end
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_drain(output bit ok);
    int k = 0;
    while (!(idle && ev_q.size() >= exp_q.size()) && k < 3000) begin @(negedge clk); k++; end
    ok = idle && (ev_q.size() >= exp_q.size());
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b need 0", cmd_ready); end
    n_tests++; if ({go, drop_full, arm_timeout, idle} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b need 0000", {go, drop_full, arm_timeout, idle}); end
    n_tests++; if (w_out !== '0 || fifo_level !== '0) begin n_fail++; $display("FAIL reset_fields: got %h lvl %0d need 0", w_out, fifo_level); end
    rst_n = 1;
    @(negedge clk);
    n_tests++; if (cmd_ready !== 1'b1 || idle !== 1'b1) begin n_fail++; $display("FAIL reset_release: ready %0b idle %0b need 1 1", cmd_ready, idle); end
  endtask

  task automatic test_create_quad();
    cmd_t c; int pc; bit ok;
    ev_q.delete(); exp_q.delete();
    resp_mode = 0; busy_len = 5; model_full = 0; obj_mem_full = 0;
    c = '{op: 4'h0, code: 4'h1, typ: 2'd3, color: 8'h5A, num: 5'd2,
          v: {16'd100, 16'd200, 16'd200, 16'd200, 16'd200, 16'd100, 16'd100, 16'd100}};
    push(c, pc); model_expect(c, 1);
    wait_drain(ok);
    n_tests++; if (!ok || ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL quad_events: got %0d need %0d", ev_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_tests++; if (ev_q[i].kind !== exp_q[i].kind || ev_q[i].c !== exp_q[i].c) begin n_fail++; $display("FAIL quad_ev%0d: got kind %0d %h need kind %0d %h", i, ev_q[i].kind, ev_q[i].c, exp_q[i].kind, exp_q[i].c); end
    end
    if (ev_q.size() > 0) begin
      n_tests++; if (ev_q[0].cyc !== pc + 3) begin n_fail++; $display("FAIL quad_latency: go at %0d need %0d", ev_q[0].cyc, pc + 3); end
    end
    n_tests++; if (hold_viol !== 0 || go_double !== 0 || go_busy_viol !== 0) begin n_fail++; $display("FAIL quad_protocol: hold %0d double %0d go_busy %0d need 0", hold_viol, go_double, go_busy_viol); end
  endtask

  task automatic test_back_to_back();
    cmd_t c; int pc, rel, rdy_seen; bit ok;
    ev_q.delete(); exp_q.delete();
    @(negedge clk);
    resp_mode = 2; busy = 1; busy_len = 3;
    for (int i = 0; i < DEPTH + 1; i++) begin
      c = rand_cmd(); c.op = 4'h4; push(c, pc); model_expect(c, 1);
    end
    n_tests++; if (fifo_level !== DEPTH || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: lvl %0d ready %0b need %0d 0", fifo_level, cmd_ready, DEPTH); end
    c = rand_cmd(); c.op = 4'h6;
    cmd_valid = 1; cmd_op = c.op; cmd_code = c.code; cmd_obj_type = c.typ;
    cmd_color = c.color; cmd_obj_num = c.num; cmd_v = c.v;
    rdy_seen = 0;
    repeat (3) begin @(negedge clk); if (cmd_ready) rdy_seen++; end
    n_tests++; if (rdy_seen !== 0 || ev_q.size() !== 0 || fifo_level !== DEPTH) begin n_fail++; $display("FAIL b2b_stall: ready %0d go %0d lvl %0d need 0 0 %0d", rdy_seen, ev_q.size(), fifo_level, DEPTH); end
    resp_mode = 0; busy = 0; rel = cyc;
    push(c, pc); model_expect(c, 1);
    wait_drain(ok);
    n_tests++; if (!ok || ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_events: got %0d need %0d", ev_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_tests++; if (ev_q[i].kind !== exp_q[i].kind || ev_q[i].c !== exp_q[i].c) begin n_fail++; $display("FAIL b2b_ev%0d: got kind %0d %h need kind %0d %h", i, ev_q[i].kind, ev_q[i].c, exp_q[i].kind, exp_q[i].c); end
      if (i > 0) begin
        n_tests++; if (ev_q[i].cyc - ev_q[i-1].cyc !== busy_len + 4) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d need %0d", i, ev_q[i].cyc - ev_q[i-1].cyc, busy_len + 4); end
      end
    end
    if (ev_q.size() > 0) begin
      n_tests++; if (ev_q[0].cyc !== rel + 1) begin n_fail++; $display("FAIL b2b_first_go: at %0d need %0d", ev_q[0].cyc, rel + 1); end
    end
    n_tests++; if (go_busy_viol !== 0 || hold_viol !== 0) begin n_fail++; $display("FAIL b2b_protocol: go_busy %0d hold %0d need 0", go_busy_viol, hold_viol); end
  endtask

  task automatic test_drop_full();
    cmd_t c1, c2; int pc1, pc2; bit ok;
    ev_q.delete(); exp_q.delete();
    resp_mode = 0; busy_len = 4; model_full = 1; obj_mem_full = 1;
    c1 = rand_cmd(); c1.op = 4'h0; c1.typ = 2'd1;
    push(c1, pc1); model_expect(c1, 1);
    wait_drain(ok);
    c2 = rand_cmd(); c2.op = 4'h4; c2.num = 5'd1; c2.v[15:0] = 16'd500;
    push(c2, pc2); model_expect(c2, 1);
    wait_drain(ok);
    obj_mem_full = 0; model_full = 0;
    n_tests++; if (!ok || ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_events: got %0d need %0d", ev_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_tests++; if (ev_q[i].kind !== exp_q[i].kind || ev_q[i].c !== exp_q[i].c) begin n_fail++; $display("FAIL drop_ev%0d: got kind %0d %h need kind %0d %h", i, ev_q[i].kind, ev_q[i].c, exp_q[i].kind, exp_q[i].c); end
    end
    if (ev_q.size() > 1) begin
      n_tests++; if (ev_q[0].cyc !== pc1 + 2 || ev_q[1].cyc !== pc2 + 3) begin n_fail++; $display("FAIL drop_timing: drop %0d go %0d need %0d %0d", ev_q[0].cyc, ev_q[1].cyc, pc1 + 2, pc2 + 3); end
    end
  endtask

  task automatic test_arm_timeout();
    cmd_t c1, c2; int pc, k; bit ok;
    ev_q.delete(); exp_q.delete();
    resp_mode = 1; busy_len = 3; model_full = 0;
    c1 = rand_cmd(); c1.op = 4'h6; c2 = rand_cmd(); c2.op = 4'h4;
    push(c1, pc); model_expect(c1, 0);
    push(c2, pc); model_expect(c2, 1);
    k = 0;
    while (ev_q.size() == 0 && k < 50) begin @(negedge clk); k++; end
    resp_mode = 0;
    wait_drain(ok);
    n_tests++; if (!ok || ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL to_events: got %0d need %0d", ev_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_tests++; if (ev_q[i].kind !== exp_q[i].kind || ev_q[i].c !== exp_q[i].c) begin n_fail++; $display("FAIL to_ev%0d: got kind %0d %h need kind %0d %h", i, ev_q[i].kind, ev_q[i].c, exp_q[i].kind, exp_q[i].c); end
    end
    if (ev_q.size() > 2) begin
      n_tests++; if (ev_q[1].cyc !== ev_q[0].cyc + ARM_TO) begin n_fail++; $display("FAIL to_delay: timeout at %0d need %0d", ev_q[1].cyc, ev_q[0].cyc + ARM_TO); end
      n_tests++; if (ev_q[2].cyc !== ev_q[1].cyc + 3) begin n_fail++; $display("FAIL to_next_go: at %0d need %0d", ev_q[2].cyc, ev_q[1].cyc + 3); end
    end
  endtask

  task automatic test_reset_mid();
    cmd_t c[3]; int pc, k;
    ev_q.delete(); exp_q.delete();
    resp_mode = 0; busy_len = 20;
    for (int i = 0; i < 3; i++) begin c[i] = rand_cmd(); c[i].op = 4'h4; push(c[i], pc); end
    k = 0;
    while (ev_q.size() == 0 && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    n_tests++; if (fifo_level !== 2) begin n_fail++; $display("FAIL mid_level_before: got %0d need 2", fifo_level); end
    rst_n = 0;
    @(negedge clk);
    m_issued = 0; m_dropped = 0; m_timeouts = 0;
    n_tests++; if (fifo_level !== 0 || go !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset: lvl %0d go %0b ready %0b need 0 0 0", fifo_level, go, cmd_ready); end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got %0b need 1", idle); end
    repeat (40) @(negedge clk);
    n_tests++; if (ev_q.size() !== 1 || ev_q[0].c !== c[0]) begin n_fail++; $display("FAIL mid_flush: events %0d need 1 (only first command)", ev_q.size()); end
  endtask

  task automatic test_random();
    cmd_t c; int pc, n, last; bit ok;
    for (int r = 0; r < 4; r++) begin
      ev_q.delete(); exp_q.delete();
      resp_mode = 0; busy_len = $urandom_range(1, 6);
      model_full = 1'($urandom_range(0, 1)); obj_mem_full = model_full;
      n = $urandom_range(8, 14);
      for (int i = 0; i < n; i++) begin
        c = rand_cmd(); push(c, pc); model_expect(c, 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain(ok);
      obj_mem_full = 0; model_full = 0;
      n_tests++; if (!ok || ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_events: got %0d need %0d", r, ev_q.size(), exp_q.size()); end
      last = -1000;
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
        n_tests++; if (ev_q[i].kind !== exp_q[i].kind || ev_q[i].c !== exp_q[i].c) begin n_fail++; $display("FAIL rnd%0d_ev%0d: got kind %0d %h need kind %0d %h", r, i, ev_q[i].kind, ev_q[i].c, exp_q[i].kind, exp_q[i].c); end
        if (ev_q[i].kind == 1) begin
          n_tests++; if (ev_q[i].cyc - last < busy_len + 4) begin n_fail++; $display("FAIL rnd%0d_gap%0d: got %0d need >= %0d", r, i, ev_q[i].cyc - last, busy_len + 4); end
          last = ev_q[i].cyc;
        end
      end
    end
    n_tests++; if (hold_viol !== 0 || go_double !== 0 || go_busy_viol !== 0) begin n_fail++; $display("FAIL rnd_protocol: hold %0d double %0d go_busy %0d need 0", hold_viol, go_double, go_busy_viol); end
  endtask

`ifdef DISP_STATS_EN
  task automatic test_stats();
    n_tests++; if (stat_issued !== 16'(m_issued)) begin n_fail++; $display("FAIL stat_issued: got %0d need %0d", stat_issued, m_issued); end
    n_tests++; if (stat_dropped !== 16'(m_dropped)) begin n_fail++; $display("FAIL stat_dropped: got %0d need %0d", stat_dropped, m_dropped); end
    n_tests++; if (stat_timeouts !== 16'(m_timeouts)) begin n_fail++; $display("FAIL stat_timeouts: got %0d need %0d", stat_timeouts, m_timeouts); end
  endtask
`endif

  initial begin
    test_reset();
    test_create_quad();
    test_back_to_back();
    test_drop_full();
    test_arm_timeout();
    test_reset_mid();
    test_create_quad();
    test_drop_full();
    test_arm_timeout();
`ifdef DISP_STATS_EN
    test_stats();
`endif
    test_random();
`ifdef DISP_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
